core_ifu: RTL and testbench
===========================

// Module: core_ifu
// PURPOSE
//  Instruction fetch unit: owns the architectural fetch PC and issues word fetches to instruction memory.
//  Buffers returned instructions and hands {pc, instr, snpc} to the IF/ID register over a valid/ready handshake.
//  Accepts branch/jump redirects from the controller and discards wrong-path work.
//  Producer end of the decode-stage input (pc_i/instr_i/snpc_i).
// PARAMETERS
//  RESET_PC    64'h0000_0000_8000_0000  first fetch address after reset
//  BUF_DEPTH   2                        fetch buffer entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock; all state on rising edge
//  rst             in   1   asynchronous, active-high reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  64  fetch address, word aligned
//  imem_rsp_valid  in   1   response valid (>=1 cycle after accept, in order, always accepted)
//  imem_rsp_instr  in   32  fetched instruction
//  imem_rsp_err    in   1   access fault for this response
//  redirect_valid  in   1   controller redirect (taken branch/jump)
//  redirect_pc     in   64  redirect target
//  if2id_valid     out  1   buffer head valid
//  if2id_ready     in   1   IF/ID register accepts head
//  if2id_pc        out  64  pc of head
//  if2id_instr     out  32  instruction of head
//  if2id_snpc      out  64  pc + 4 of head
//  if2id_fault     out  1   head carries fetch fault (misaligned or access error)
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, state IDLE, buffer empty, imem_req_valid=0, imem_req_addr=RESET_PC,
//   if2id_valid=0, if2id_pc=0, if2id_instr=32'h0000_0013 (NOP), if2id_snpc=0, if2id_fault=0.
//  At most one outstanding fetch. Credit: issue only if buf_count + outstanding < BUF_DEPTH.
//  FSM:
//   IDLE      -> REQ when credit and not halted; first REQ in cycle 1 after reset release.
//   REQ       imem_req_valid=1, addr=pc_q; addr/valid held stable until accepted.
//             accept -> WAIT, pc_q += 4 (64-bit wrap).
//             redirect before accept -> DROP_REQ; pc_q<=redirect_pc.
//   WAIT      rsp -> push {addr, instr, err}; -> REQ if credit, else IDLE.
//             redirect -> DROP_RSP, pc_q<=redirect_pc; redirect+rsp same cycle -> discard rsp, -> IDLE.
//   DROP_REQ  keep stale request until accepted -> DROP_RSP.
//   DROP_RSP  discard next response -> IDLE.
//  Redirect: flushes buffer in the same edge; if2id_valid forced 0 in the redirect cycle,
//   so no pop occurs; redirect wins over simultaneous push/pop.
//  A second redirect while dropping only updates pc_q.
//  redirect_pc[1:0]!=0: no memory access; push one entry {redirect_pc, NOP, fault=1}; halt issue
//   until next redirect.
//  imem_rsp_err=1: entry pushed with fault=1, instr=NOP; halt issue until next redirect.
//  Buffer: push and pop in the same cycle allowed when not full; no push when full (credit guarantees).
//   Head data appears on if2id_* the cycle after push (no bypass).
//  if2id_snpc = if2id_pc + 4, computed from the head entry. Empty buffer drives the reset values.
//  Reset asserted mid-operation: all state cleared immediately; outstanding response after reset
//   release is not expected (memory is reset together).
//  Best-case throughput: 1 instr / 2 cycles (single outstanding fetch), with 1-cycle memory.
// STRUCTURE
//  defines.v: `CPU_PC_SIZE, `CPU_INSTR_SIZE, `INSTR_NOP (32'h0000_0013), IFU state encodings
//   (IDLE/REQ/WAIT/DROP_REQ/DROP_RSP).
//  Sub-module core_ifu_fifo: synchronous FIFO, width 97 {pc, instr, fault}, parameter BUF_DEPTH,
//   with flush, push, pop, full, empty, count.
//  Top holds the FSM, pc_q, halt flag and credit logic.
// TESTING
//  1. Reset release, 1-cycle memory, if2id_ready=1: addresses 0x8000_0000, +4, +8 in order;
//     if2id_snpc = pc+4.
//  2. if2id_ready=0 held: exactly BUF_DEPTH pushes, then imem_req_valid stays 0; ready=1 resumes.
//  3. Redirect to 0x8000_0100 while in WAIT: stale response dropped, buffer flushed,
//     next request addr 0x8000_0100.
//  4. imem_req_ready low 3 cycles with redirect on cycle 1: addr stays stable until accept,
//     stale rsp dropped, then fetch 0x8000_0100.
//  5. Redirect to 0x8000_0102: single entry, fault=1, instr=0x13, no imem_req until next redirect.
//  6. rsp_err=1 at 0x8000_0008: entry fault=1, fetch halts; rst asserted mid-WAIT clears all
//     state, refetch RESET_PC.

Source files
------------

// File: rtl/core_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Fetch-buffer entries carry {pc, instr, fault}.
package core_ifu_pkg;

    localparam int CPU_PC_SIZE    = 32'd64;
    localparam int CPU_INSTR_SIZE = 32'd32;

    localparam logic [CPU_INSTR_SIZE-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        IFU_IDLE     = 3'd0,
        IFU_REQ      = 3'd1,
        IFU_WAIT     = 3'd2,
        IFU_DROP_REQ = 3'd3,
        IFU_DROP_RSP = 3'd4
    } ifu_state_e;

    typedef struct packed {
        logic [CPU_PC_SIZE-1:0]    pc;
        logic [CPU_INSTR_SIZE-1:0] instr;
        logic                      fault;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic is_misaligned(input logic [CPU_PC_SIZE-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/core_ifu_if.sv
// Bundle of the fetch unit's memory, redirect and IF/ID handshake signals.
// The master modport is the fetch unit; the slave modport is its environment.
interface core_ifu_if;
    import core_ifu_pkg::*;

    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [CPU_PC_SIZE-1:0]    imem_req_addr;
    logic                      imem_rsp_valid;
    logic [CPU_INSTR_SIZE-1:0] imem_rsp_instr;
    logic                      imem_rsp_err;
    logic                      redirect_valid;
    logic [CPU_PC_SIZE-1:0]    redirect_pc;
    logic                      if2id_valid;
    logic                      if2id_ready;
    logic [CPU_PC_SIZE-1:0]    if2id_pc;
    logic [CPU_INSTR_SIZE-1:0] if2id_instr;
    logic [CPU_PC_SIZE-1:0]    if2id_snpc;
    logic                      if2id_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_instr, imem_rsp_err,
        input  redirect_valid, redirect_pc,
        output if2id_valid, if2id_pc, if2id_instr, if2id_snpc, if2id_fault,
        input  if2id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_instr, imem_rsp_err,
        output redirect_valid, redirect_pc,
        input  if2id_valid, if2id_pc, if2id_instr, if2id_snpc, if2id_fault,
        output if2id_ready
    );

endinterface

// File: rtl/core_ifu_fifo.sv
// Fetch buffer: circular FIFO of fetch entries.
// A flush empties it, and a push in the same cycle becomes the sole surviving entry.
module core_ifu_fifo
    import core_ifu_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  fetch_entry_t               push_data,
    output fetch_entry_t               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(BUF_DEPTH):0] count
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 32'd1;

    fetch_entry_t     mem_r [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [PTR_W-1:0] wr_idx_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_W'(BUF_DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // A flush frees every slot, so a push alongside it always lands in slot 0.
    assign do_push_s = push && (flush || !full);
    assign do_pop_s  = pop && !empty && !flush;
    assign wr_idx_s  = flush ? {PTR_W{1'b0}} : wr_ptr_r;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= do_push_s ? PTR_W'(1) : {PTR_W{1'b0}};
            count_r  <= do_push_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else begin
            wr_ptr_r <= do_push_s ? wr_ptr_r + PTR_W'(1) : wr_ptr_r;
            rd_ptr_r <= do_pop_s ? rd_ptr_r + PTR_W'(1) : rd_ptr_r;
            count_r  <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 32'sd0; i < BUF_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

endmodule

// File: rtl/core_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one fetch in flight against a credit,
// buffers responses for the IF/ID register and discards wrong-path work on redirect.
module core_ifu
    import core_ifu_pkg::*;
#(
    parameter logic [CPU_PC_SIZE-1:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter int                     BUF_DEPTH = 32'd2
) (
    input  logic        clk,
    input  logic        rst,
    core_ifu_if.master  bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 32'd1;
    localparam int OCC_W = CNT_W + 32'd1;

    ifu_state_e              state_r;
    ifu_state_e              state_nxt_s;
    logic [CPU_PC_SIZE-1:0]  pc_r;
    logic [CPU_PC_SIZE-1:0]  pc_nxt_s;
    logic [CPU_PC_SIZE-1:0]  fsm_pc_s;
    logic [CPU_PC_SIZE-1:0]  req_addr_r;
    logic                    req_valid_r;
    logic                    halt_r;
    logic                    halt_nxt_s;
    logic                    fsm_halt_s;
    logic                    fsm_push_s;
    logic                    redirect_s;
    logic                    redirect_bad_s;
    logic                    req_accept_s;
    logic                    rsp_s;
    logic                    credit_idle_s;
    logic                    credit_rsp_s;
    logic [OCC_W-1:0]        occ_after_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    head_valid_s;
    fetch_entry_t            push_data_s;
    fetch_entry_t            rsp_entry_s;
    fetch_entry_t            bad_entry_s;
    fetch_entry_t            head_s;
    logic                    fifo_full_s;
    logic                    fifo_empty_s;
    logic [CNT_W-1:0]        fifo_count_s;

    assign redirect_s     = bus.redirect_valid;
    assign redirect_bad_s = redirect_s && is_misaligned(bus.redirect_pc);
    assign req_accept_s   = req_valid_r && bus.imem_req_ready;
    assign rsp_s          = bus.imem_rsp_valid;

    // The head is hidden during a redirect so nothing is consumed from a buffer about to be flushed.
    assign head_valid_s = !fifo_empty_s && !redirect_s;
    assign pop_s        = head_valid_s && bus.if2id_ready;

    // Credit with nothing in flight, and credit after the response arriving now is pushed.
    assign credit_idle_s = !fifo_full_s;
    assign occ_after_s   = {1'b0, fifo_count_s} + OCC_W'(1) - OCC_W'(pop_s);
    assign credit_rsp_s  = (occ_after_s < OCC_W'(BUF_DEPTH));

    assign rsp_entry_s = '{pc: req_addr_r,
                           instr: bus.imem_rsp_err ? INSTR_NOP : bus.imem_rsp_instr,
                           fault: bus.imem_rsp_err};
    assign bad_entry_s = '{pc: bus.redirect_pc, instr: INSTR_NOP, fault: 1'b1};

    // Fetch sequencing; redirect effects on pc/halt/push are merged in below.
    always_comb begin
        state_nxt_s = state_r;
        fsm_pc_s    = pc_r;
        fsm_halt_s  = halt_r;
        fsm_push_s  = 1'b0;
        case (state_r)
            IFU_IDLE: begin
                if (!redirect_s && !halt_r && credit_idle_s) begin
                    state_nxt_s = IFU_REQ;
                end else begin
                    state_nxt_s = IFU_IDLE;
                end
            end
            IFU_REQ: begin
                if (redirect_s) begin
                    state_nxt_s = req_accept_s ? IFU_DROP_RSP : IFU_DROP_REQ;
                end else if (req_accept_s) begin
                    state_nxt_s = IFU_WAIT;
                    fsm_pc_s    = pc_r + 64'd4;
                end else begin
                    state_nxt_s = IFU_REQ;
                end
            end
            IFU_WAIT: begin
                if (redirect_s) begin
                    state_nxt_s = rsp_s ? IFU_IDLE : IFU_DROP_RSP;
                end else if (rsp_s) begin
                    fsm_push_s = 1'b1;
                    if (bus.imem_rsp_err) begin
                        fsm_halt_s  = 1'b1;
                        state_nxt_s = IFU_IDLE;
                    end else if (credit_rsp_s) begin
                        state_nxt_s = IFU_REQ;
                    end else begin
                        state_nxt_s = IFU_IDLE;
                    end
                end else begin
                    state_nxt_s = IFU_WAIT;
                end
            end
            IFU_DROP_REQ: begin
                state_nxt_s = req_accept_s ? IFU_DROP_RSP : IFU_DROP_REQ;
            end
            IFU_DROP_RSP: begin
                state_nxt_s = rsp_s ? IFU_IDLE : IFU_DROP_RSP;
            end
            default: begin
                state_nxt_s = IFU_IDLE;
            end
        endcase
    end

    // A redirect retargets the PC, and a misaligned target is reported as a single fault entry.
    assign pc_nxt_s    = redirect_s ? bus.redirect_pc : fsm_pc_s;
    assign halt_nxt_s  = redirect_s ? redirect_bad_s : fsm_halt_s;
    assign push_s      = redirect_s ? redirect_bad_s : fsm_push_s;
    assign push_data_s = redirect_s ? bad_entry_s : rsp_entry_s;

    // State, PC, halt flag and the registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IFU_IDLE;
            pc_r        <= RESET_PC;
            halt_r      <= 1'b0;
            req_valid_r <= 1'b0;
            req_addr_r  <= RESET_PC;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            halt_r      <= halt_nxt_s;
            req_valid_r <= (state_nxt_s == IFU_REQ) || (state_nxt_s == IFU_DROP_REQ);
            req_addr_r  <= (state_nxt_s == IFU_REQ) ? pc_nxt_s : req_addr_r;
        end
    end

    core_ifu_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (push_data_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    assign bus.imem_req_valid = req_valid_r;
    assign bus.imem_req_addr  = req_addr_r;
    assign bus.if2id_valid    = head_valid_s;
    assign bus.if2id_pc       = fifo_empty_s ? 64'd0 : head_s.pc;
    assign bus.if2id_instr    = fifo_empty_s ? INSTR_NOP : head_s.instr;
    assign bus.if2id_snpc     = fifo_empty_s ? 64'd0 : head_s.pc + 64'd4;
    assign bus.if2id_fault    = fifo_empty_s ? 1'b0 : head_s.fault;

endmodule

// File: tb/tb_core_ifu.sv
// Randomised bench for core_ifu: a latency-varying memory model plus a reference model of
// the in-order instruction stream that the IF/ID side must observe.
module tb_core_ifu;
    import core_ifu_pkg::*;

    localparam logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000;
    localparam int          BUF_DEPTH = 2;
    localparam logic [63:0] NO_ERR    = 64'hFFFF_FFFF_FFFF_FFF0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    core_ifu_if bus();

    core_ifu #(.RESET_PC(RESET_PC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // stimulus knobs
    int          p_req_rdy = 100;
    int          p_id_rdy  = 100;
    int          p_redir   = 0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    logic [63:0] err_addr  = NO_ERR;
    bit          dir_pending = 1'b0;
    logic [63:0] dir_pc;

    // memory model and observations
    logic [63:0] pend_addr[$];
    int          pend_wait[$];
    logic [63:0] acc_log[$];
    int          n_acc = 0;
    int          n_pop = 0;
    int          n_fault = 0;
    logic        s_valid;
    logic [63:0] s_addr;

    // reference model of the architectural instruction stream
    logic [63:0] exp_pc;
    bit          halted;
    bit          prev_stall;
    logic [63:0] prev_addr;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {a[17:2], 16'hC0DE};
    endfunction

    function automatic logic [63:0] acc_at(input int i);
        if (i < acc_log.size()) return acc_log[i];
        return 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_instr = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.if2id_ready    = 1'b0;
    endtask

    task automatic cycle();
        logic        exp_fault;
        logic [63:0] a;
        @(negedge clk);
        bus.imem_req_ready = ($urandom_range(99) < p_req_rdy);
        bus.if2id_ready    = ($urandom_range(99) < p_id_rdy);
        bus.imem_rsp_valid = 1'b0;
        if (pend_addr.size() > 0) begin
            if (pend_wait[0] <= 0) begin
                a = pend_addr.pop_front();
                void'(pend_wait.pop_front());
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_instr = mem_word(a);
                bus.imem_rsp_err   = (a == err_addr);
            end else begin
                pend_wait[0] = pend_wait[0] - 1;
            end
        end
        if (dir_pending) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = dir_pc;
            dir_pending        = 1'b0;
        end else if ($urandom_range(999) < p_redir) begin
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = RESET_PC + 64'({$urandom_range(63, 0), 2'b00})
                                 + (($urandom_range(7) == 0) ? 64'd2 : 64'd0);
        end else begin
            bus.redirect_valid = 1'b0;
        end
        #1;
        s_valid = bus.imem_req_valid;
        s_addr  = bus.imem_req_addr;
        if (prev_stall) begin
            check("req_hold_valid", bus.imem_req_valid, 1);
            check("req_hold_addr", bus.imem_req_addr, prev_addr);
        end
        if (bus.redirect_valid) check("redirect_hides_head", bus.if2id_valid, 0);
        if (bus.if2id_valid && bus.if2id_ready) begin
            exp_fault = (exp_pc[1:0] != 2'b00) || (exp_pc == err_addr);
            check("pop_after_fault", halted, 0);
            check("pop_pc", bus.if2id_pc, exp_pc);
            check("pop_instr", bus.if2id_instr, exp_fault ? 64'(INSTR_NOP) : 64'(mem_word(exp_pc)));
            check("pop_snpc", bus.if2id_snpc, exp_pc + 64'd4);
            check("pop_fault", bus.if2id_fault, exp_fault);
            if (exp_fault) begin
                halted = 1'b1;
                n_fault++;
            end
            exp_pc = exp_pc + 64'd4;
            n_pop++;
        end
        if (bus.redirect_valid) begin
            exp_pc = bus.redirect_pc;
            halted = 1'b0;
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_aligned", bus.imem_req_addr[1:0], 0);
            pend_addr.push_back(bus.imem_req_addr);
            pend_wait.push_back($urandom_range(lat_max, lat_min) - 1);
            acc_log.push_back(bus.imem_req_addr);
            n_acc++;
        end
        prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
        prev_addr  = bus.imem_req_addr;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        pend_addr.delete();
        pend_wait.delete();
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);
        check("rst_id_valid", bus.if2id_valid, 0);
        check("rst_id_pc", bus.if2id_pc, 0);
        check("rst_id_instr", bus.if2id_instr, 64'(INSTR_NOP));
        check("rst_id_snpc", bus.if2id_snpc, 0);
        check("rst_id_fault", bus.if2id_fault, 0);
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        exp_pc     = RESET_PC;
        halted     = 1'b0;
        prev_stall = 1'b0;
        acc_log.delete();
        n_acc   = 0;
        n_pop   = 0;
        n_fault = 0;
    endtask

    task automatic wait_outstanding(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle();
            seen = (pend_addr.size() > 0);
        end
        check(tag, seen, 1);
    endtask

    initial begin
        int snap;
        rst = 1'b1;
        drive_idle();

        // 1: sequential fetch with 1-cycle memory and an always-ready consumer
        do_reset();
        cycle();
        check("t1_first_req_valid", s_valid, 1);
        check("t1_first_req_addr", s_addr, RESET_PC);
        run(20);
        check("t1_acc0", acc_at(0), RESET_PC);
        check("t1_acc1", acc_at(1), RESET_PC + 64'd4);
        check("t1_acc2", acc_at(2), RESET_PC + 64'd8);
        check("t1_enough_pops", (n_pop >= 8), 1);

        // 2: consumer stalled -> exactly BUF_DEPTH fetches, then issue stops
        do_reset();
        p_id_rdy = 0;
        run(30);
        check("t2_fills", n_acc, BUF_DEPTH);
        check("t2_req_quiet", s_valid, 0);
        check("t2_no_pops", n_pop, 0);
        p_id_rdy = 100;
        run(20);
        check("t2_resumed", (n_pop > BUF_DEPTH), 1);

        // 3: redirect while a fetch is outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        wait_outstanding("t3_outstanding");
        dir_pc = RESET_PC + 64'h100; dir_pending = 1'b1;
        cycle();
        acc_log.delete();
        run(20);
        check("t3_refetch", acc_at(0), RESET_PC + 64'h100);

        // 4: memory not ready for 3 cycles, redirect during the stall
        do_reset();
        lat_min = 1; lat_max = 1;
        p_req_rdy = 0;
        cycle();
        dir_pc = RESET_PC + 64'h100; dir_pending = 1'b1;
        run(2);
        check("t4_addr_stable", s_addr, RESET_PC);
        p_req_rdy = 100;
        run(20);
        check("t4_stale_acc", acc_at(0), RESET_PC);
        check("t4_refetch", acc_at(1), RESET_PC + 64'h100);

        // 5: misaligned redirect -> one fault entry, no memory traffic until re-redirected
        do_reset();
        p_id_rdy = 0;
        run(30);
        dir_pc = RESET_PC + 64'h102; dir_pending = 1'b1;
        cycle();
        snap = n_acc;
        p_id_rdy = 100;
        run(20);
        check("t5_no_fetch", n_acc - snap, 0);
        check("t5_one_fault", n_fault, 1);
        acc_log.delete();
        dir_pc = RESET_PC + 64'h200; dir_pending = 1'b1;
        run(20);
        check("t5_resume", acc_at(0), RESET_PC + 64'h200);

        // 6: access error halts fetch; reset mid-fetch restarts from RESET_PC
        do_reset();
        err_addr = RESET_PC + 64'd8;
        run(30);
        check("t6_pops", n_pop, 3);
        check("t6_fault", n_fault, 1);
        check("t6_acc", n_acc, 3);
        check("t6_halted_quiet", s_valid, 0);
        err_addr = NO_ERR;
        lat_min = 3; lat_max = 3;
        dir_pc = RESET_PC; dir_pending = 1'b1;
        cycle();
        wait_outstanding("t6_outstanding");
        do_reset();
        lat_min = 1; lat_max = 1;
        run(20);
        check("t6_refetch", acc_at(0), RESET_PC);

        // random traffic against the stream model
        do_reset();
        p_req_rdy = 70; p_id_rdy = 60; p_redir = 40;
        lat_min = 1; lat_max = 3;
        err_addr = RESET_PC + 64'hB4;
        run(4000);
        check("rand_progress", (n_pop > 200), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
